// File: rtl/fetch_pc_gen_pkg.sv
// Shared parameters and state encoding for the fetch PC generator.
package fetch_pc_gen_pkg;

   localparam int ADDR       = 32;
   localparam int W_BRID     = 4;
   localparam int INST_BYTES = 4;
   localparam logic [ADDR-1:0] RESET_PC = '0;

   // Clears the sub-instruction byte offset of a redirect target.
   localparam logic [ADDR-1:0] ALIGN_MASK = ~(ADDR'(INST_BYTES - 1));

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch front end: instruction-memory address, redirects, halt/restart and branch-ID generation.
//
// state  | meaning
// S_BOOT | one cycle after reset; pc held, fetch stage output killed
// S_RUN  | issuing a fetch every cycle (or re-reading on stall)
// S_HALT | no fetches; left only by a redirect
import fetch_pc_gen_pkg::*;

module fetch_pc_gen (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              br_v_i,
   input  logic [ADDR-1:0]   br_target_i,
   input  logic              halt_i,
   output logic [ADDR-1:0]   pc_o,
   output logic              req_o,
   output logic [W_BRID-1:0] brid_o,
   output logic              branch_o,
   output logic              halted_o
);

   state_e              state_q, state_d;
   logic [ADDR-1:0]     pc_q, pc_d;
   logic [W_BRID-1:0]   brid_q, brid_d;
   logic [ADDR-1:0]     target_aligned;

   assign target_aligned = br_target_i & ALIGN_MASK;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
         brid_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         brid_q  <= brid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      brid_d  = brid_q;
      unique case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            // A redirect wins over both stall and halt; the wrong-path fetch is killed via branch_o.
            if (br_v_i) begin
               pc_d   = target_aligned;
               brid_d = brid_q + W_BRID'(1);
            end else if (stall_i) begin
               pc_d = pc_q;
            end else if (halt_i) begin
               state_d = S_HALT;
            end else begin
               pc_d = pc_q + ADDR'(INST_BYTES);
            end
         end
         S_HALT: begin
            if (br_v_i) begin
               pc_d    = target_aligned;
               brid_d  = brid_q + W_BRID'(1);
               state_d = S_RUN;
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_comb begin
      req_o    = (state_q == S_RUN);
      branch_o = (state_q != S_RUN) | br_v_i;
      halted_o = (state_q == S_HALT);
   end

   assign pc_o   = pc_q;
   assign brid_o = brid_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: a behavioural model queues per-cycle expectations, a monitor checks them.
import fetch_pc_gen_pkg::*;

module tb_fetch_pc_gen;

   logic              clk = 1'b0;
   logic              reset;
   logic              stall_i, br_v_i, halt_i;
   logic [ADDR-1:0]   br_target_i;
   logic [ADDR-1:0]   pc_o;
   logic              req_o, branch_o, halted_o;
   logic [W_BRID-1:0] brid_o;

   fetch_pc_gen dut (
      .clk         (clk),
      .reset       (reset),
      .stall_i     (stall_i),
      .br_v_i      (br_v_i),
      .br_target_i (br_target_i),
      .halt_i      (halt_i),
      .pc_o        (pc_o),
      .req_o       (req_o),
      .brid_o      (brid_o),
      .branch_o    (branch_o),
      .halted_o    (halted_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  brid;
      logic        req;
      logic        branch;
      logic        halted;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // model: 0 = boot, 1 = run, 2 = halt
   int          m_st;
   logic [31:0] m_pc;
   logic [3:0]  m_brid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("pc_o",     pc_o,     e.pc);
         chk("brid_o",   32'(brid_o), 32'(e.brid));
         chk("req_o",    32'(req_o),    32'(e.req));
         chk("branch_o", 32'(branch_o), 32'(e.branch));
         chk("halted_o", 32'(halted_o), 32'(e.halted));
      end
   end

   // Drive one cycle of inputs, queue what the outputs must be during it, then advance the model.
   task automatic step(input logic rst, input logic stall, input logic br,
                       input logic [31:0] tgt, input logic halt);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; stall_i = stall; br_v_i = br; br_target_i = tgt; halt_i = halt;
      e.pc     = m_pc;
      e.brid   = m_brid;
      e.req    = (m_st == 1);
      e.branch = (m_st != 1) || br;
      e.halted = (m_st == 2);
      exp_q.push_back(e);
      if (rst) begin
         m_st = 0; m_pc = 32'h0; m_brid = 4'h0;
      end else if (m_st == 0) begin
         m_st = 1;
      end else if (br) begin
         m_st = 1; m_pc = {tgt[31:2], 2'b00}; m_brid = 4'((int'(m_brid) + 1) % 16);
      end else if (m_st == 1) begin
         if (stall) ;
         else if (halt) m_st = 2;
         else m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; stall_i = 1'b0; br_v_i = 1'b0; halt_i = 1'b0; br_target_i = '0;
      repeat (2) @(posedge clk);
      m_st = 0; m_pc = 32'h0; m_brid = 4'h0;

      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);                      // BOOT cycle
      chk("boot_req", 32'(req_o), 32'd0);
      repeat (4) step(0, 0, 0, 0, 0);           // pc 0,4,8,12
      chk("run_pc12", pc_o, 32'hC);
      repeat (3) step(0, 1, 0, 0, 0);           // stall at 0x10
      chk("stall_pc", pc_o, 32'h10);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("after_stall_pc", pc_o, 32'h14);
      repeat (2) step(0, 0, 0, 0, 0);
      step(0, 1, 1, 32'h103, 0);                // redirect during stall at 0x20
      chk("redir_pc_before", pc_o, 32'h20);
      step(0, 0, 0, 0, 0);
      chk("redir_pc", pc_o, 32'h100);
      chk("redir_brid", 32'(brid_o), 32'd1);

      for (int i = 0; i < 15; i++) step(0, 0, 1, 32'h300 + 32'(i * 8), 0);
      step(0, 0, 0, 0, 0);
      chk("brid_wrap", 32'(brid_o), 32'd0);

      step(0, 0, 1, 32'hFFFF_FFFC, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("pc_wrap", pc_o, 32'h0);

      step(0, 0, 1, 32'h40, 0);
      step(0, 0, 0, 0, 1);                      // halt at 0x40
      step(0, 0, 0, 0, 1);
      chk("halt_pc", pc_o, 32'h40);
      chk("halted", 32'(halted_o), 32'd1);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 32'h80, 0);                 // restart
      step(0, 0, 0, 0, 0);
      chk("restart_pc", pc_o, 32'h80);
      chk("restart_halted", 32'(halted_o), 32'd0);

      step(0, 0, 1, 32'h55, 1);                 // redirect beats halt
      step(0, 0, 0, 0, 0);
      chk("br_over_halt", 32'(req_o), 32'd1);

      step(1, 0, 1, 32'h200, 0);                // reset beats redirect
      step(0, 0, 0, 0, 0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_brid", 32'(brid_o), 32'd0);

      for (int i = 0; i < 200; i++)
         step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
              $urandom, ($urandom_range(0, 9) == 0));
      step(0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
